// File: rtl/cbus_mem_responder_pkg.sv
// Shared CBus request/response types, burst encodings and the responder state enum.
package cbus_mem_responder_pkg;

    typedef logic [2:0] msize_t;
    // Beat count minus one: 0 means a single beat, 15 means sixteen beats.
    typedef logic [3:0] mlen_t;
    typedef logic [1:0] axi_burst_t;

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } cbus_resp_state_t;

endpackage

// File: rtl/cbus_mem_responder_ram.sv
// 64-bit word RAM with a combinational read port and a byte-strobed synchronous write port.
module byte_write_ram #(
    parameter int unsigned WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] waddr,
    input  logic [63:0]              wdata,
    input  logic [7:0]               wstrb,
    input  logic [$clog2(WORDS)-1:0] raddr,
    output logic [63:0]              rdata
);

    logic [63:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 8; k++) begin
                if (wstrb[k]) begin
                    mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cbus_mem_responder.sv
// CBus responder: latches a request, waits LATENCY cycles, then streams len+1 beats
// to or from the backing RAM.
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    cbus_resp_state_t state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    mlen_t            len_q, len_d;
    mlen_t            beat_q, beat_d;
    logic [3:0]       cnt_q, cnt_d;
    axi_burst_t       burst_q, burst_d;
    logic             write_q, write_d;

    logic            active;
    logic [IdxW-1:0] beat_idx;
    logic [63:0]     rdata;

    logic unused_req_bits;
    assign unused_req_bits = ^{creq.size, creq.addr[31:IdxW+3], creq.addr[2:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            burst_q <= AXI_BURST_FIXED;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        write_d = write_q;
        unique case (state_q)
            IDLE: begin
                if (creq.valid) begin
                    idx_d   = creq.addr[IdxW+2:3];
                    len_d   = creq.len;
                    burst_d = creq.burst;
                    write_d = creq.is_write;
                    beat_d  = '0;
                    if (LATENCY > 0) begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = WAIT;
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            WAIT: begin
                if (!creq.valid) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = BURST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BURST: begin
                if (!creq.valid) begin
                    state_d = IDLE;
                end else if (beat_q == len_q) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Dropping valid mid-burst gates the beat off in the same cycle.
    always_comb begin
        active   = (state_q == BURST) && creq.valid;
        beat_idx = (burst_q == AXI_BURST_FIXED) ? idx_q : idx_q + IdxW'(beat_q);
        cresp.ready = active;
        cresp.last  = active && (beat_q == len_q);
        cresp.data  = (active && !write_q) ? rdata : 64'd0;
    end

    byte_write_ram #(
        .WORDS (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (active && write_q),
        .waddr (beat_idx),
        .wdata (creq.data),
        .wstrb (creq.strobe),
        .raddr (beat_idx),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 0, 3) driven from a vector table plus
// hand-written abort, back-to-back and reset sequences; per-cycle scoreboard against a model.
module tb_cbus_mem_responder;
    import cbus_mem_responder_pkg::*;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] addr;
        int          n;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [63:0] base;
        logic [63:0] exp0;
    } vec_t;

    logic       clk;
    logic       resetn;
    cbus_req_t  creq_a  [3];
    cbus_resp_t cresp_a [3];

    logic [63:0] model [3][1024];
    exp_t        exp_q [$];
    int          n_vec;
    int          n_bad;

    cbus_mem_responder #(.MEM_WORDS(1024), .LATENCY(1)) u_dut_l1 (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq_a[0]),
        .cresp  (cresp_a[0])
    );

    cbus_mem_responder #(.MEM_WORDS(1024), .LATENCY(0)) u_dut_l0 (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq_a[1]),
        .cresp  (cresp_a[1])
    );

    cbus_mem_responder #(.MEM_WORDS(1024), .LATENCY(3)) u_dut_l3 (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq_a[2]),
        .cresp  (cresp_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic int idx_of(input logic [31:0] addr, input int beat, input logic [1:0] burst);
        logic [9:0] base;
        base = addr[12:3];
        if (burst == AXI_BURST_FIXED || beat <= 0) return int'(base);
        return int'(base + 10'(beat));
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got ready=%0b last=%0b data=%h, want ready=%0b last=%0b data=%h",
                     name, got.ready, got.last, got.data, want.ready, want.last, want.data);
        end
    endtask

    function automatic exp_t sample(input int d);
        exp_t g;
        g.ready = cresp_a[d].ready;
        g.last  = cresp_a[d].last;
        g.data  = cresp_a[d].data;
        return g;
    endfunction

    // One transaction, checked every cycle; abort_beat >= 0 drops valid on that beat.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input int n,
                        input logic [1:0] burst, input logic [7:0] strb, input logic [63:0] base,
                        input int abort_beat, output logic [63:0] first_rd);
        int lat;
        lat = lat_of(d);
        first_rd = '0;
        for (int c = 0; c <= lat + n + 1; c++) begin
            int          beat;
            bit          in_b;
            bit          abt;
            int          idx;
            logic [63:0] wd;
            exp_t        e;
            exp_t        g;
            beat = c - lat - 1;
            in_b = (beat >= 0) && (beat < n);
            abt  = in_b && (beat == abort_beat);
            idx  = idx_of(addr, beat, burst);
            wd   = base + 64'((beat > 0) ? beat : 0);
            @(posedge clk);
            #1;
            creq_a[d].valid    = (c <= lat + n) && !abt;
            creq_a[d].is_write = wr;
            creq_a[d].size     = 3'd3;
            creq_a[d].addr     = addr;
            creq_a[d].strobe   = strb;
            creq_a[d].data     = wr ? wd : 64'd0;
            creq_a[d].len      = 4'(n - 1);
            creq_a[d].burst    = burst;
            e.ready = in_b && !abt;
            e.last  = e.ready && (beat == n - 1);
            e.data  = (e.ready && !wr) ? model[d][idx] : 64'd0;
            exp_q.push_back(e);
            @(negedge clk);
            g = sample(d);
            e = exp_q.pop_front();
            check($sformatf("xfer d%0d %s addr=%h cyc%0d", d, wr ? "wr" : "rd", addr, c), g, e);
            if (e.ready && !wr && beat == 0) first_rd = g.data;
            if (e.ready && wr) begin
                for (int k = 0; k < 8; k++) begin
                    if (strb[k]) model[d][idx][8*k +: 8] = wd[8*k +: 8];
                end
            end
            if (abt) break;
        end
        creq_a[d].valid = 1'b0;
    endtask

    vec_t        vecs [$];
    logic [63:0] rd0;
    exp_t        e;
    exp_t        g;

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        resetn = 1'b0;
        for (int d = 0; d < 3; d++) creq_a[d] = '0;

        vecs.push_back('{0, 1'b1, 32'h40,   1,  AXI_BURST_INCR,  8'hFF, 64'h1122334455667788, 64'h0});
        vecs.push_back('{0, 1'b0, 32'h40,   1,  AXI_BURST_INCR,  8'hFF, 64'h0, 64'h1122334455667788});
        vecs.push_back('{0, 1'b1, 32'h40,   1,  AXI_BURST_INCR,  8'h0F, 64'hAAAAAAAAAAAAAAAA, 64'h0});
        vecs.push_back('{0, 1'b0, 32'h40,   1,  AXI_BURST_INCR,  8'hFF, 64'h0, 64'h11223344AAAAAAAA});
        vecs.push_back('{0, 1'b1, 32'h1FF0, 4,  AXI_BURST_INCR,  8'hFF, 64'h1000, 64'h0});
        vecs.push_back('{0, 1'b0, 32'h1FF0, 4,  AXI_BURST_INCR,  8'hFF, 64'h0, 64'h1000});
        vecs.push_back('{0, 1'b0, 32'h0,    2,  AXI_BURST_INCR,  8'hFF, 64'h0, 64'h1002});
        vecs.push_back('{0, 1'b1, 32'h28,   1,  AXI_BURST_INCR,  8'hFF, 64'hDEAD, 64'h0});
        vecs.push_back('{0, 1'b0, 32'h28,   3,  AXI_BURST_FIXED, 8'hFF, 64'h0, 64'hDEAD});
        vecs.push_back('{0, 1'b1, 32'h100,  2,  2'b11,           8'hFF, 64'h2000, 64'h0});
        vecs.push_back('{0, 1'b0, 32'h108,  1,  AXI_BURST_INCR,  8'hFF, 64'h0, 64'h2001});
        vecs.push_back('{0, 1'b1, 32'h300,  2,  AXI_BURST_FIXED, 8'hFF, 64'h6000, 64'h0});
        vecs.push_back('{0, 1'b0, 32'h300,  1,  AXI_BURST_INCR,  8'hFF, 64'h0, 64'h6001});
        vecs.push_back('{0, 1'b1, 32'h200,  16, AXI_BURST_INCR,  8'hFF, 64'h5000, 64'h0});
        vecs.push_back('{0, 1'b0, 32'h200,  16, AXI_BURST_INCR,  8'hFF, 64'h0, 64'h5000});
        vecs.push_back('{1, 1'b1, 32'h80,   1,  AXI_BURST_INCR,  8'hFF, 64'h3000, 64'h0});
        vecs.push_back('{1, 1'b0, 32'h80,   1,  AXI_BURST_INCR,  8'hFF, 64'h0, 64'h3000});
        vecs.push_back('{2, 1'b1, 32'h80,   1,  AXI_BURST_INCR,  8'hFF, 64'h4000, 64'h0});
        vecs.push_back('{2, 1'b0, 32'h80,   2,  AXI_BURST_INCR,  8'hFF, 64'h0, 64'h4000});

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check($sformatf("reset d%0d", d), sample(d), '0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].n, vecs[i].burst, vecs[i].strb,
                 vecs[i].base, -1, rd0);
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d first beat", i), '{1'b1, 1'b0, rd0},
                      '{1'b1, 1'b0, vecs[i].exp0});
            end
        end

        // Abort on beat 2 of a 4-beat write: only beats 0 and 1 land; next request accepted at once.
        xfer(0, 1'b1, 32'h400, 4, AXI_BURST_INCR, 8'hFF, 64'hA000, -1, rd0);
        xfer(0, 1'b1, 32'h400, 4, AXI_BURST_INCR, 8'hFF, 64'hB000, 2, rd0);
        xfer(0, 1'b0, 32'h410, 2, AXI_BURST_INCR, 8'hFF, 64'h0, -1, rd0);
        check("abort word2 unchanged", '{1'b1, 1'b0, rd0}, '{1'b1, 1'b0, 64'hA002});
        xfer(0, 1'b0, 32'h400, 4, AXI_BURST_INCR, 8'hFF, 64'h0, -1, rd0);
        check("abort word0 written", '{1'b1, 1'b0, rd0}, '{1'b1, 1'b0, 64'hB000});

        // LATENCY=0 with valid held: beats at cycles 1, 4, 7 (two dead cycles between).
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            creq_a[1].valid    = 1'b1;
            creq_a[1].is_write = 1'b0;
            creq_a[1].addr     = 32'h80;
            creq_a[1].len      = 4'd0;
            creq_a[1].burst    = AXI_BURST_INCR;
            e.ready = (c % 3 == 1);
            e.last  = e.ready;
            e.data  = e.ready ? 64'h3000 : 64'h0;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("b2b cyc%0d", c), sample(1), e);
        end
        creq_a[1].valid = 1'b0;
        repeat (3) @(posedge clk);

        // Reset during beat 1 of a read burst.
        @(posedge clk);
        #1;
        creq_a[0].valid    = 1'b1;
        creq_a[0].is_write = 1'b0;
        creq_a[0].addr     = 32'h1FF0;
        creq_a[0].len      = 4'd3;
        creq_a[0].burst    = AXI_BURST_INCR;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre-reset beat1", sample(0), '{1'b1, 1'b0, 64'h1001});
        #1;
        resetn = 1'b0;
        #1;
        check("reset mid-read", sample(0), '0);
        creq_a[0].valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("held in reset", sample(0), '0);
        resetn = 1'b1;
        xfer(0, 1'b0, 32'h40, 1, AXI_BURST_INCR, 8'hFF, 64'h0, -1, rd0);
        check("persist 0x40", '{1'b1, 1'b0, rd0}, '{1'b1, 1'b0, 64'h11223344AAAAAAAA});
        xfer(0, 1'b0, 32'h1FF0, 4, AXI_BURST_INCR, 8'hFF, 64'h0, -1, rd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
